// File: rtl/gauss_win_reader.sv
// gauss_win_reader: snapshots the 6x6 Gaussian buffer when sobel_en asserts.
// It then streams every 3x3 window in raster order to the Sobel core over a
// valid/ready handshake, and pulses frame_done once the last window is taken.
// Optional feature macro: READER_CLAMP_EN saturates output pixels to 8 bits.
module gauss_win_reader #(
    parameter int PIX_W   = 9,
    parameter int BUF_DIM = 6,
    parameter int WIN_DIM = 3
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          sobel_en,
    input  logic [BUF_DIM-1:0][BUF_DIM-1:0][PIX_W-1:0]    buffer_in,
    input  logic                                          win_ready,
    output logic                                          win_valid,
    output logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0]    win_data,
    output logic [1:0]                                    win_row,
    output logic [1:0]                                    win_col,
    output logic                                          busy,
    output logic                                          frame_done
);

    localparam int               POS       = BUF_DIM - WIN_DIM + 1;
    localparam logic [1:0]       LAST      = 2'(POS - 1);
    localparam logic [PIX_W-1:0] CLAMP_MAX = PIX_W'(255);

    typedef logic [BUF_DIM-1:0][BUF_DIM-1:0][PIX_W-1:0] buf_t;
    typedef logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_t;

    state_t     state;
    buf_t       snap;
    logic [1:0] next_row;
    logic [1:0] next_col;
    logic       handshake;

    // Cut the window at (r,c) out of the snapshot; the snapshot itself stays raw.
    function automatic win_t window_at(input buf_t s, input logic [1:0] r,
                                       input logic [1:0] c);
        win_t             w;
        logic [PIX_W-1:0] p;
        w = '0;
        for (int i = 0; i < WIN_DIM; i++) begin
            for (int j = 0; j < WIN_DIM; j++) begin
                p = s[int'(r) + i][int'(c) + j];
`ifdef READER_CLAMP_EN
                if (p[PIX_W-1]) begin
                    p = CLAMP_MAX;
                end
`endif
                w[i][j] = p;
            end
        end
        return w;
    endfunction

    // Raster-order successor of the current position: column first, then row.
    always_comb begin
        next_col  = win_col + 2'd1;
        next_row  = win_row;
        handshake = win_valid && win_ready;
        if (win_col == LAST) begin
            next_col = 2'd0;
            next_row = win_row + 2'd1;
        end
    end

    // Frame sequencer: capture, preload window (0,0), stream, flag completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_row    <= 2'd0;
            win_col    <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    if (sobel_en) begin
                        snap    <= buffer_in;
                        win_row <= 2'd0;
                        win_col <= 2'd0;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    win_data  <= window_at(snap, 2'd0, 2'd0);
                    win_valid <= 1'b1;
                    state     <= STREAM;
                end
                STREAM: begin
                    if (handshake) begin
                        if (win_row == LAST && win_col == LAST) begin
                            win_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            win_row  <= next_row;
                            win_col  <= next_col;
                            win_data <= window_at(snap, next_row, next_col);
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gauss_win_reader.sv
// Testbench for gauss_win_reader: random and patterned frames checked against
// a reference built directly from the window definition snap[r+i][c+j].
module tb_gauss_win_reader;

    localparam int PIX_W   = 9;
    localparam int BUF_DIM = 6;
    localparam int WIN_DIM = 3;
    localparam int POS     = BUF_DIM - WIN_DIM + 1;

    logic                                       clk;
    logic                                       rst;
    logic                                       sobel_en;
    logic [BUF_DIM-1:0][BUF_DIM-1:0][PIX_W-1:0] buffer_in;
    logic                                       win_ready;
    logic                                       win_valid;
    logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win_data;
    logic [1:0]                                 win_row;
    logic [1:0]                                 win_col;
    logic                                       busy;
    logic                                       frame_done;

    int checks = 0;
    int errors = 0;
    int exp_buf[BUF_DIM][BUF_DIM];

    gauss_win_reader #(.PIX_W(PIX_W), .BUF_DIM(BUF_DIM), .WIN_DIM(WIN_DIM)) dut (
        .clk(clk), .rst(rst), .sobel_en(sobel_en), .buffer_in(buffer_in),
        .win_ready(win_ready), .win_valid(win_valid), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .busy(busy), .frame_done(frame_done)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pixel as the Sobel core should see it.
    function automatic logic [PIX_W-1:0] exp_pix(input int r, input int c);
        int v;
        v = exp_buf[r][c];
`ifdef READER_CLAMP_EN
        if (v > 255) v = 255;
`endif
        return PIX_W'(v);
    endfunction

    function automatic logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] exp_window(input int r, input int c);
        logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] w;
        for (int i = 0; i < WIN_DIM; i++)
            for (int j = 0; j < WIN_DIM; j++)
                w[i][j] = exp_pix(r + i, c + j);
        return w;
    endfunction

    // mode 0: 10*r+c, mode 1: random 9-bit, mode 2: all 9'h1FF
    task automatic load_buffer(input int mode);
        for (int r = 0; r < BUF_DIM; r++)
            for (int c = 0; c < BUF_DIM; c++) begin
                if (mode == 0) exp_buf[r][c] = 10 * r + c;
                else if (mode == 1) exp_buf[r][c] = int'($urandom_range(0, 511));
                else exp_buf[r][c] = 511;
                buffer_in[r][c] = PIX_W'(exp_buf[r][c]);
            end
    endtask

    // Runs one frame from IDLE; stall_k/stall_len hold ready low at window index stall_k.
    task automatic run_stream(input string name, input int stall_k, input int stall_len,
                              input bit rand_stall, input bit corrupt);
        int k, cycles, stalls, stalled, guard, exp_len;
        bit ready;
        sobel_en = 1'b1;
        @(negedge clk);
        sobel_en = 1'b0;
        cycles = 0;
        checks++;
        if (busy !== 1'b1 || win_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_load: busy=%b valid=%b, expected busy=1 valid=0", name, busy, win_valid);
        end
        if (corrupt)
            for (int r = 0; r < BUF_DIM; r++)
                for (int c = 0; c < BUF_DIM; c++)
                    buffer_in[r][c] = PIX_W'(7);
        @(negedge clk);
        cycles++;
        k = 0; stalls = 0; stalled = 0; guard = 0;
        while (k < POS * POS && guard < 400) begin
            guard++;
            checks++;
            if (win_valid !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_valid k=%0d: valid=%b done=%b, expected 1/0", name, k, win_valid, frame_done);
            end
            checks++;
            if (win_row !== 2'(k / POS) || win_col !== 2'(k % POS)) begin
                errors++;
                $display("[TB] FAIL %s_pos k=%0d: got (%0d,%0d) expected (%0d,%0d)", name, k, win_row, win_col, k / POS, k % POS);
            end
            checks++;
            if (win_data !== exp_window(k / POS, k % POS)) begin
                errors++;
                $display("[TB] FAIL %s_data k=%0d: got %h expected %h", name, k, win_data, exp_window(k / POS, k % POS));
            end
            ready = 1'b1;
            if (k == stall_k && stalled < stall_len) begin
                ready = 1'b0;
                stalled++;
            end else if (rand_stall && $urandom_range(0, 2) == 0) begin
                ready = 1'b0;
            end
            if (!ready) stalls++;
            win_ready = ready;
            if (corrupt) sobel_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            cycles++;
            if (ready) k++;
        end
        if (guard >= 400) begin
            errors++;
            $display("[TB] FAIL %s_timeout: handshakes=%0d expected %0d", name, k, POS * POS);
        end
        sobel_en  = 1'b0;
        win_ready = 1'($urandom_range(0, 1));
        checks++;
        if (frame_done !== 1'b1 || win_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done: done=%b valid=%b busy=%b, expected 1/0/1", name, frame_done, win_valid, busy);
        end
        @(negedge clk);
        cycles++;
        exp_len = 18 + stalls;
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0 || cycles != exp_len) begin
            errors++;
            $display("[TB] FAIL %s_idle: done=%b busy=%b len=%0d, expected 0/0/%0d", name, frame_done, busy, cycles, exp_len);
        end
        win_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_norestart: valid=%b busy=%b done=%b, expected 0", name, win_valid, busy, frame_done);
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (win_valid !== 1'b0 || win_data !== '0 || win_row !== 2'd0 || win_col !== 2'd0 ||
            busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: valid=%b data=%h row=%0d col=%0d busy=%b done=%b, expected all 0",
                     win_valid, win_data, win_row, win_col, busy, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (win_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_idle: valid=%b busy=%b done=%b, expected 0", win_valid, busy, frame_done);
            end
        end
    endtask

    task automatic test_full_frame();
        load_buffer(0);
        run_stream("full", -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_buffer(1);
        run_stream("bp", 1 * POS + 2, 3, 1'b0, 1'b0);
    endtask

    task automatic test_random_ready();
        for (int n = 0; n < 3; n++) begin
            load_buffer(1);
            run_stream("rand", -1, 0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_snapshot_isolation();
        load_buffer(1);
        run_stream("iso", -1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        int k;
        load_buffer(1);
        sobel_en = 1'b1;
        @(negedge clk);
        sobel_en = 1'b0;
        @(negedge clk);
        win_ready = 1'b1;
        k = 0;
        while (k < 2 * POS + 1) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (win_row !== 2'd2 || win_col !== 2'd1 || win_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_pos: got (%0d,%0d) valid=%b expected (2,1) valid=1", win_row, win_col, win_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (win_valid !== 1'b0 || busy !== 1'b0 || win_data !== '0 || win_row !== 2'd0) begin
            errors++;
            $display("[TB] FAIL midrst_async: valid=%b busy=%b data=%h row=%0d, expected 0", win_valid, busy, win_data, win_row);
        end
        @(negedge clk);
        rst = 1'b0;
        win_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (frame_done !== 1'b0 || win_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midrst_quiet: done=%b valid=%b busy=%b, expected 0", frame_done, win_valid, busy);
            end
        end
        load_buffer(1);
        run_stream("midrst_restart", -1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        load_buffer(2);
        run_stream("clamp", -1, 0, 1'b1, 1'b0);
    endtask

    // Scenario sequence; every scenario starts and ends with the reader idle.
    initial begin
        rst = 1'b0;
        sobel_en = 1'b0;
        win_ready = 1'b0;
        buffer_in = '0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_random_ready();
        test_snapshot_isolation();
        test_reset_mid_frame();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
